apb_txn_sched: RTL



---
 rtl/apb_txn_sched.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/apb_txn_sched.sv
// rtl/apb_txn_sched.sv - round-robin write/read command arbiter driving one APB master port
// Optional build macro: APB_TIMEOUT_EN (bounds ACCESS wait states to TIMEOUT_MAX cycles)
module apb_txn_sched #(
  parameter int ID_NUM      = 4,
  parameter int ADDR_W      = 12,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_MAX = 255
) (
  input  logic                          ACLK_i,
  input  logic                          ARESETn_i,
  input  logic                          wr_vld_i,
  output logic                          wr_rdy_o,
  input  logic [ID_NUM+ADDR_W+DATA_W-1:0] wr_payload_i,
  input  logic                          rd_vld_i,
  output logic                          rd_rdy_o,
  input  logic [ID_NUM+ADDR_W-1:0]      rd_payload_i,
  output logic                          PSEL_o,
  output logic                          PENABLE_o,
  output logic                          PWRITE_o,
  output logic [ADDR_W-1:0]             PADDR_o,
  output logic [DATA_W-1:0]             PWDATA_o,
  input  logic [DATA_W-1:0]             PRDATA_i,
  input  logic                          PREADY_i,
  input  logic                          PSLVERR_i,
  output logic                          bvld_o,
  input  logic                          brdy_i,
  output logic [ID_NUM-1:0]             bid_o,
  output logic                          berr_o,
  output logic                          rvld_o,
  input  logic                          rrdy_i,
  output logic [ID_NUM-1:0]             rid_o,
  output logic [DATA_W-1:0]             rdata_o,
  output logic                          rerr_o
);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_RESP} state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic [ID_NUM-1:0]   r_id;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_data;
  logic                r_dir;       // 1 = write
  logic                r_last_wr;   // 1 = last grant went to the write side
  logic                r_berr;
  logic                r_rerr;
  logic [DATA_W-1:0]   r_rdata;

  logic                w_grant_wr;
  logic                w_grant_rd;
  logic                w_wr_hs;
  logic                w_rd_hs;
  logic                w_resp_hs;
  logic                w_timeout;

  // A parameter outside the 8-bit counter range can never be reached
  if (TIMEOUT_MAX < 1 || TIMEOUT_MAX > 255) begin : g_bad_timeout
    $error("TIMEOUT_MAX must be in 1..255");
  end

  // Round robin: a lone requester always wins, contention goes to the side not served last
  assign w_grant_wr = wr_vld_i & (~rd_vld_i | ~r_last_wr);
  assign w_grant_rd = rd_vld_i & (~wr_vld_i |  r_last_wr);
  assign w_wr_hs    = wr_vld_i & wr_rdy_o;
  assign w_rd_hs    = rd_vld_i & rd_rdy_o;
  assign w_resp_hs  = (r_state == S_RESP) & (r_dir ? brdy_i : rrdy_i);

`ifdef APB_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_MAX - 1);

  logic [7:0]          r_wait_cnt;

  // The cycle that would be wait state number TIMEOUT_MAX ends the transfer instead
  assign w_timeout = (r_state == S_ACCESS) & ~PREADY_i & (r_wait_cnt == TO_LAST);

  // Wait-state counter: cleared in SETUP so every ACCESS phase starts from zero
  always_ff @(posedge ACLK_i) begin
    if (!ARESETn_i) begin
      r_wait_cnt <= '0;
    end else if (r_state == S_SETUP) begin
      r_wait_cnt <= '0;
    end else if ((r_state == S_ACCESS) && !PREADY_i) begin
      r_wait_cnt <= r_wait_cnt + 8'd1;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  // State register
  always_ff @(posedge ACLK_i) begin
    if (!ARESETn_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and state-decoded outputs
  always_comb begin
    w_state_nxt = r_state;
    wr_rdy_o    = 1'b0;
    rd_rdy_o    = 1'b0;
    PSEL_o      = 1'b0;
    PENABLE_o   = 1'b0;
    bvld_o      = 1'b0;
    rvld_o      = 1'b0;
    case (r_state)
      S_IDLE: begin
        // Gated by reset so nothing is offered while the block is held in reset
        wr_rdy_o = ARESETn_i & w_grant_wr;
        rd_rdy_o = ARESETn_i & w_grant_rd;
        if (w_wr_hs || w_rd_hs) w_state_nxt = S_SETUP;
      end
      S_SETUP: begin
        PSEL_o      = 1'b1;
        w_state_nxt = S_ACCESS;
      end
      S_ACCESS: begin
        PSEL_o    = 1'b1;
        PENABLE_o = 1'b1;
        if (PREADY_i || w_timeout) w_state_nxt = S_RESP;
      end
      S_RESP: begin
        bvld_o = r_dir;
        rvld_o = ~r_dir;
        if (w_resp_hs) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Command latch, arbitration history and response capture
  always_ff @(posedge ACLK_i) begin
    if (!ARESETn_i) begin
      r_id      <= '0;
      r_addr    <= '0;
      r_data    <= '0;
      r_dir     <= 1'b0;
      r_last_wr <= 1'b0;
      r_berr    <= 1'b0;
      r_rerr    <= 1'b0;
      r_rdata   <= '0;
    end else begin
      if (w_wr_hs) begin
        r_id      <= wr_payload_i[ID_NUM+ADDR_W+DATA_W-1 -: ID_NUM];
        r_addr    <= wr_payload_i[ADDR_W+DATA_W-1 -: ADDR_W];
        r_data    <= wr_payload_i[DATA_W-1:0];
        r_dir     <= 1'b1;
        r_last_wr <= 1'b1;
      end else if (w_rd_hs) begin
        r_id      <= rd_payload_i[ID_NUM+ADDR_W-1 -: ID_NUM];
        r_addr    <= rd_payload_i[ADDR_W-1:0];
        r_data    <= '0;
        r_dir     <= 1'b0;
        r_last_wr <= 1'b0;
      end
      if (r_state == S_ACCESS) begin
        if (PREADY_i) begin
          if (r_dir) begin
            r_berr  <= PSLVERR_i;
          end else begin
            r_rerr  <= PSLVERR_i;
            r_rdata <= PRDATA_i;
          end
        end else if (w_timeout) begin
          if (r_dir) begin
            r_berr  <= 1'b1;
          end else begin
            r_rerr  <= 1'b1;
            r_rdata <= '0;
          end
        end
      end
    end
  end

  assign PWRITE_o = r_dir;
  assign PADDR_o  = r_addr;
  assign PWDATA_o = r_data;
  assign bid_o    = r_id;
  assign rid_o    = r_id;
  assign berr_o   = r_berr;
  assign rerr_o   = r_rerr;
  assign rdata_o  = r_rdata;

endmodule
